// File: rtl/tmr_scrub_regfile.sv
// Triplicated DEPTH x WIDTH register file: bitwise-majority voted reads plus a
// background scrubber that rewrites any word whose three copies disagree.
module tmr_scrub_regfile #(
    parameter int WIDTH          = 8,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_err,
    input  logic              scrub_en,
    input  logic              err_clear,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IW    = $clog2(SCRUB_INTERVAL);

    // The CHECK cycle is the last of each interval, so WAIT lasts SCRUB_INTERVAL-1 cycles.
    localparam logic [IW-1:0]    RELOAD    = IW'(SCRUB_INTERVAL - 1);
    localparam logic [IW-1:0]    LAST_WAIT = IW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        WAIT  = 1'b0,
        CHECK = 1'b1
    } scrub_state_t;

    function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    function automatic logic disagree3(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic [WIDTH-1:0] c);
        return |((a ^ b) | (b ^ c));
    endfunction

    logic [WIDTH-1:0]  memA [DEPTH];
    logic [WIDTH-1:0]  memB [DEPTH];
    logic [WIDTH-1:0]  memC [DEPTH];

    scrub_state_t      state_r;
    scrub_state_t      state_next_s;
    logic [IW-1:0]     interval_r;
    logic [ADDR_W-1:0] scrub_ptr;

    logic              check_s;
    logic              count_s;
    logic [WIDTH-1:0]  rd_vote_s;
    logic              rd_dis_s;
    logic [WIDTH-1:0]  scrub_vote_s;
    logic              scrub_dis_s;
    logic              wr_hits_scrub_s;
    logic              scrub_fix_s;

    // Scrubber state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Scrubber next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WAIT: begin
                if (scrub_en && (interval_r <= LAST_WAIT)) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = WAIT;
                end
            end
            CHECK:   state_next_s = WAIT;
            default: state_next_s = WAIT;
        endcase
    end

    // Scrubber control outputs
    always_comb begin
        check_s = 1'b0;
        count_s = 1'b0;
        case (state_r)
            WAIT:    count_s = scrub_en;
            CHECK:   check_s = 1'b1;
            default: check_s = 1'b0;
        endcase
    end

    // Interval counter: holds while the scrubber is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            interval_r <= RELOAD;
        end else if (check_s) begin
            interval_r <= RELOAD;
        end else if (count_s) begin
            interval_r <= interval_r - IW'(1);
        end else begin
            interval_r <= interval_r;
        end
    end

    // Voting on the read port and on the word under scrub
    always_comb begin
        rd_vote_s       = vote3(memA[rd_addr], memB[rd_addr], memC[rd_addr]);
        rd_dis_s        = disagree3(memA[rd_addr], memB[rd_addr], memC[rd_addr]);
        scrub_vote_s    = vote3(memA[scrub_ptr], memB[scrub_ptr], memC[scrub_ptr]);
        scrub_dis_s     = disagree3(memA[scrub_ptr], memB[scrub_ptr], memC[scrub_ptr]);
        wr_hits_scrub_s = wr_en && (wr_addr == scrub_ptr);
        // A user write to the scrubbed word supersedes the repair and is not counted.
        if (check_s && scrub_dis_s && !wr_hits_scrub_s) begin
            scrub_fix_s = 1'b1;
        end else begin
            scrub_fix_s = 1'b0;
        end
    end

    // Triplicated storage: scrub repair first, user write has the final say
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                memA[i] <= {WIDTH{1'b0}};
                memB[i] <= {WIDTH{1'b0}};
                memC[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (scrub_fix_s) begin
                memA[scrub_ptr] <= scrub_vote_s;
                memB[scrub_ptr] <= scrub_vote_s;
                memC[scrub_ptr] <= scrub_vote_s;
            end
            if (wr_en) begin
                memA[wr_addr] <= wr_data;
                memB[wr_addr] <= wr_data;
                memC[wr_addr] <= wr_data;
            end
        end
    end

    // Scrub pointer advances after every CHECK, wrapping naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_ptr <= {ADDR_W{1'b0}};
        end else if (check_s) begin
            scrub_ptr <= scrub_ptr + ADDR_W'(1);
        end else begin
            scrub_ptr <= scrub_ptr;
        end
    end

    // Registered read port (pre-write data on a same-address collision)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {WIDTH{1'b0}};
            rd_err  <= 1'b0;
        end else begin
            rd_data <= rd_vote_s;
            rd_err  <= rd_dis_s;
        end
    end

    // Correction counter and sticky flag; clear wins over a same-cycle event
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= {CNT_W{1'b0}};
            err_flag  <= 1'b0;
        end else if (err_clear) begin
            err_count <= {CNT_W{1'b0}};
            err_flag  <= 1'b0;
        end else begin
            if (scrub_fix_s && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (scrub_fix_s || rd_dis_s) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/tmr_scrub_regfile.md
Name: tmr_scrub_regfile

Overview:
Parametrised successor to the single self-correcting TMR flip-flop: a DEPTH x WIDTH register file with three copies of each word, bitwise majority voting on read, and a background scrubber.
- The scrubber walks the address space, detects copy disagreement and rewrites all three copies with the voted value.
- A saturating error counter and a sticky flag record corrections.
- Used for SEU-hardened configuration and status storage.

Parameters:
WIDTH, 8, data bits per word
ADDR_W, 4, address bits; DEPTH = 2**ADDR_W words
SCRUB_INTERVAL, 64, clock cycles between scrub checks (>=2)
CNT_W, 8, width of the correction counter

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
rd_addr  in  ADDR_W  read address, sampled every cycle
rd_data  out  WIDTH  voted read data, registered
rd_err  out  1  copies of the read word disagreed, aligned with rd_data
scrub_en  in  1  enables the background scrubber
err_clear  in  1  clears err_count and err_flag
err_count  out  CNT_W  number of scrub corrections, saturating
err_flag  out  1  sticky: any disagreement seen (read or scrub)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Storage: three arrays memA, memB, memC (names fixed; the bench uses them as hierarchical fault-injection points). Voted word = bitwise majority (A&B)|(B&C)|(A&C). Disagreement = any bit where A, B and C are not all equal.
- Reset:
  - all copies = 0, rd_data = 0, rd_err = 0
  - err_count = 0, err_flag = 0
  - scrub_ptr = 0, interval counter reloaded, FSM = WAIT
  - reset during CHECK aborts the check with no write and no count
- Write: when wr_en=1, the word at wr_addr is written in all three copies on that edge. Any latent disagreement at that address is removed without a count.
- Read:
  - latency 1: rd_data/rd_err at edge N+1 reflect rd_addr at edge N
  - read and write to the same address in the same cycle return the old (pre-write) voted value
  - rd_err=1 sets err_flag but does not correct the copies and does not increment err_count
- Scrubber FSM, two states:
  - WAIT: interval counter counts from SCRUB_INTERVAL-1 down to 0. At 0, go to CHECK. When scrub_en=0, the counter holds and the FSM stays in WAIT.
  - CHECK (1 cycle): vote the word at scrub_ptr.
    - On disagreement: on this edge, write the voted word into all three copies, err_count += 1 (saturates at 2**CNT_W-1), err_flag = 1.
    - Always: scrub_ptr += 1, wrapping DEPTH-1 -> 0; counter reloaded; FSM -> WAIT.
  - One word is checked every SCRUB_INTERVAL cycles. A full sweep takes DEPTH*SCRUB_INTERVAL cycles.
- Collisions and priority:
  - wr_en with wr_addr == scrub_ptr during CHECK: user data is written, no scrub correction, no count. The pointer still advances.
  - err_clear has priority over a same-cycle increment or flag set: result is err_count = 0, err_flag = 0.
  - A scrub disagreement and a read disagreement in the same cycle still add only 1 to the count (scrub only).
- Single-bit or multi-bit faults confined to one copy are fully corrected. The block does not detect identical faults in two copies; they are voted as the correct value.

Test Plan:
(WIDTH=8, ADDR_W=4, SCRUB_INTERVAL=4, CNT_W=2 unless noted.)
1. Basic write/read:
   - Stimulus: rst, then write 0xA5 to addr 3; read addr 3 on the next cycle.
   - Response: rd_data=0xA5 one cycle later, rd_err=0, err_flag=0.
2. Read correction without repair:
   - Stimulus: flip bit 0 of memB[3] (0xA5 -> 0xA4), scrub_en=0, read addr 3.
   - Response: rd_data=0xA5, rd_err=1, err_flag=1, err_count=0, memB[3] stays 0xA4.
3. Scrub repair:
   - Stimulus: as scenario 2, then scrub_en=1 from reset state.
   - Response: addr 3 is checked in the 4th CHECK (cycle 16 after enable). memB[3]=0xA5 afterwards, err_count=1. The pointer wraps to 0 after addr 15.
4. Saturation and clear:
   - Stimulus: inject faults in copy C at addrs 0..4; run one sweep.
   - Response: err_count saturates at 3, never wraps.
   - Stimulus: assert err_clear in the same cycle as a further correction.
   - Response: err_count=0, err_flag=0.
5. Write/scrub collision:
   - Stimulus: fault in memA[5]; assert wr_en, wr_addr=5, wr_data=0x3C in the CHECK cycle for addr 5.
   - Response: all copies = 0x3C, err_count unchanged, scrub_ptr=6.
6. Reset mid-operation:
   - Stimulus: assert rst during CHECK with a pending fault.
   - Response: next cycle all copies = 0, scrub_ptr=0, err_count=0, rd_data=0, FSM in WAIT.
